// File: rtl/apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | apb_pkg : shared APB master types, state encoding and defaults   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package apb_pkg;

  localparam int unsigned C_APB_ADDR_W = 32;
  localparam int unsigned C_APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Request/response bundles at the default widths, for integrators
  typedef struct packed {
    logic                        write;
    logic [C_APB_ADDR_W-1:0]     addr;
    logic [C_APB_DATA_W-1:0]     wdata;
    logic [C_APB_DATA_W/8-1:0]   strb;
  } apb_req_t;

  typedef struct packed {
    logic [C_APB_DATA_W-1:0]     rdata;
    logic                        err;
  } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | apb_wait_timer : saturating wait-state counter with abort flag   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_enabled
      localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);
      localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (count_en && (cnt_q != C_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Flags the edge on which this increment would make the count reach TIMEOUT
      assign expired = count_en && (cnt_q == C_LAST);
    end else begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, count_en};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | apb_master_ctrl : APB4 master, valid/ready request side          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = C_APB_ADDR_W,
  parameter int unsigned DATA_W  = C_APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic                PSLVERR,
  input  logic [DATA_W-1:0]   PRDATA
);

  apb_state_e          state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (w_timer_clear),
    .count_en (w_timer_en),
    .expired  (w_timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_write ? req_wdata : '0;
          pstrb_d   = req_write ? req_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d     = 1'b1;
        w_timer_clear = 1'b1;
        state_d       = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = IDLE;
        end else begin
          w_timer_en = 1'b1;
          if (w_timer_expired) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_apb_master_ctrl : directed self-checking bench, TIMEOUT = 4   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_apb_master_ctrl;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic                PCLK = 1'b0;
  logic                PRESET;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_strb;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic                PREADY;
  logic                PSLVERR;
  logic [DATA_W-1:0]   PRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling or driving
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;

    step();
    step();
    PRESET = 1'b0;

    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_psel",      64'(PSEL),      64'd0);
    check("rst_penable",   64'(PENABLE),   64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_paddr",     64'(PADDR),     64'd0);
    check("rst_pwdata",    64'(PWDATA),    64'd0);

    // Zero-wait write
    PREADY = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    req_valid = 1'b0;
    check("wr_setup_psel",    64'(PSEL),      64'd1);
    check("wr_setup_penable", 64'(PENABLE),   64'd0);
    check("wr_setup_ready",   64'(req_ready), 64'd0);
    check("wr_setup_pwrite",  64'(PWRITE),    64'd1);
    check("wr_setup_paddr",   64'(PADDR),     64'h10);
    check("wr_setup_pwdata",  64'(PWDATA),    64'hDEADBEEF);
    check("wr_setup_pstrb",   64'(PSTRB),     64'hF);
    step();
    check("wr_access_psel",    64'(PSEL),      64'd1);
    check("wr_access_penable", 64'(PENABLE),   64'd1);
    check("wr_access_rsp",     64'(rsp_valid), 64'd0);
    check("wr_access_paddr",   64'(PADDR),     64'h10);
    check("wr_access_pwdata",  64'(PWDATA),    64'hDEADBEEF);
    step();
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_err",   64'(rsp_err),   64'd0);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("wr_done_psel", 64'(PSEL),      64'd0);
    check("wr_done_pen",  64'(PENABLE),   64'd0);
    check("wr_done_rdy",  64'(req_ready), 64'd1);
    check("wr_hold_addr", 64'(PADDR),     64'h10);
    step();
    check("wr_rsp_pulse", 64'(rsp_valid), 64'd0);

    // Read with 3 wait states; final edge coincides with counter reaching TIMEOUT-1
    PREADY = 1'b0;
    PRDATA = 32'h12345678;
    issue(1'b0, 32'h20, 32'hAAAA5555, 4'hF);
    step();
    req_valid = 1'b0;
    check("rd_setup_paddr",  64'(PADDR),  64'h20);
    check("rd_setup_pwrite", 64'(PWRITE), 64'd0);
    check("rd_setup_pwdata", 64'(PWDATA), 64'd0);
    check("rd_setup_pstrb",  64'(PSTRB),  64'd0);
    step();
    check("rd_access_penable", 64'(PENABLE), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_wait_rsp",     64'(rsp_valid), 64'd0);
      check("rd_wait_psel",    64'(PSEL),      64'd1);
      check("rd_wait_pstrb",   64'(PSTRB),     64'd0);
      check("rd_wait_pwdata",  64'(PWDATA),    64'd0);
      check("rd_wait_ready",   64'(req_ready), 64'd0);
    end
    PREADY = 1'b1;
    step();
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    check("rd_rsp_err",   64'(rsp_err),   64'd0);
    check("rd_done_psel", 64'(PSEL),      64'd0);

    // Slave error on a write
    PSLVERR = 1'b1;
    issue(1'b1, 32'h30, 32'h000000FF, 4'h1);
    step();
    req_valid = 1'b0;
    check("err_setup_pstrb", 64'(PSTRB), 64'h1);
    step();
    step();
    check("err_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_rsp_err",   64'(rsp_err),   64'd1);
    check("err_rsp_rdata", 64'(rsp_rdata), 64'd0);
    PSLVERR = 1'b0;

    // Timeout: PREADY held low, abort on the 4th ACCESS edge
    PREADY = 1'b0;
    PRDATA = 32'hCAFEF00D;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait_rsp",  64'(rsp_valid), 64'd0);
      check("to_wait_psel", 64'(PSEL),      64'd1);
    end
    step();
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    check("to_rsp_err",   64'(rsp_err),   64'd1);
    check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("to_psel",      64'(PSEL),      64'd0);
    check("to_penable",   64'(PENABLE),   64'd0);
    check("to_ready",     64'(req_ready), 64'd1);

    // Next request after timeout completes normally
    PREADY = 1'b1;
    issue(1'b1, 32'h50, 32'h0BADF00D, 4'h3);
    step();
    req_valid = 1'b0;
    check("post_to_psel",  64'(PSEL),  64'd1);
    check("post_to_paddr", 64'(PADDR), 64'h50);
    step();
    step();
    check("post_to_rsp",   64'(rsp_valid), 64'd1);
    check("post_to_err",   64'(rsp_err),   64'd0);

    // Reset while in ACCESS, with PREADY high to prove reset priority
    PREADY = 1'b0;
    issue(1'b0, 32'h60, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    step();
    check("mr_in_access", 64'(PENABLE), 64'd1);
    PRESET = 1'b1;
    PREADY = 1'b1;
    step();
    PRESET = 1'b0;
    PREADY = 1'b0;
    check("mr_psel",    64'(PSEL),      64'd0);
    check("mr_penable", 64'(PENABLE),   64'd0);
    check("mr_paddr",   64'(PADDR),     64'd0);
    check("mr_rsp",     64'(rsp_valid), 64'd0);
    check("mr_ready",   64'(req_ready), 64'd1);
    step();
    check("mr_rsp_after", 64'(rsp_valid), 64'd0);

    // Back-to-back with req_valid held high
    PREADY = 1'b1;
    issue(1'b1, 32'h70, 32'h11111111, 4'hF);
    step();
    req_addr  = 32'h74;
    req_wdata = 32'h22222222;
    check("b2b_1_paddr", 64'(PADDR),     64'h70);
    check("b2b_1_ready", 64'(req_ready), 64'd0);
    step();
    check("b2b_1_access_paddr", 64'(PADDR),     64'h70);
    check("b2b_1_access_ready", 64'(req_ready), 64'd0);
    step();
    check("b2b_1_rsp",   64'(rsp_valid), 64'd1);
    check("b2b_1_ready2", 64'(req_ready), 64'd1);
    check("b2b_1_psel0", 64'(PSEL),      64'd0);
    step();
    req_valid = 1'b0;
    check("b2b_2_psel",    64'(PSEL),      64'd1);
    check("b2b_2_penable", 64'(PENABLE),   64'd0);
    check("b2b_2_paddr",   64'(PADDR),     64'h74);
    check("b2b_2_pwdata",  64'(PWDATA),    64'h22222222);
    check("b2b_2_ready",   64'(req_ready), 64'd0);
    check("b2b_2_rsp",     64'(rsp_valid), 64'd0);
    step();
    step();
    check("b2b_2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("b2b_2_ready_end", 64'(req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB4 master controller replacing the fixed 32-bit, task-driven master. Accepts single read/write requests from a local requester over a valid/ready handshake and runs a compliant IDLE→SETUP→ACCESS transfer on the APB bus. Adds byte strobes, slave-error reporting, and a programmable wait-state timeout. Returns every transfer as a one-cycle response pulse. Sits between the system-side requester and the APB slaves.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width; multiple of 8
- TIMEOUT, 16, maximum PREADY-low cycles in ACCESS before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request (high only in IDLE)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  one-cycle completion pulse; no back-pressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PREADY, PSLVERR  in  1  slave ready and error
- PRDATA  in  DATA_W  slave read data

## Operation
- States: IDLE, SETUP, ACCESS. The reset state is IDLE.
- **IDLE**
  - req_ready=1.
  - On req_valid, register addr, write, wdata, and strb into PADDR, PWRITE, PWDATA, and PSTRB.
  - Set PSEL=1 and PENABLE=0, then go to SETUP.
- **Reads:** PWDATA=0 and PSTRB=0.
- **SETUP:** set PENABLE=1 and go to ACCESS unconditionally. Clear the wait counter.
- **ACCESS, PREADY=1**
  - Set PSEL=0 and PENABLE=0, and go to IDLE.
  - Set rsp_valid=1.
  - rsp_rdata = PRDATA if read, else 0.
  - rsp_err = PSLVERR.
- **ACCESS, PREADY=0**
  - Increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, abort:
    - set PSEL=0 and PENABLE=0, and go to IDLE;
    - set rsp_valid=1, rsp_err=1, rsp_rdata=0.
- **Address and data hold:** PADDR, PWRITE, PWDATA, and PSTRB hold their values from SETUP until the next accepted request. They never change while PSEL=1.
- **Request inputs:** ignored outside IDLE. The requester must hold req_* stable until the handshake completes.
- **Counter width:** $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- **Reset values:** all outputs 0 after a PRESET edge, except req_ready=1 (state IDLE).
- **Reset mid-transfer:** PRESET has priority in every state. It drops PSEL and PENABLE on the same edge and produces no rsp_valid.
- **Request accept:** at edge E0 (req_valid && req_ready).
  - After E0: SETUP is visible on the bus and req_ready=0.
  - After E1: ACCESS.
- **Zero-wait completion:** PREADY high during ACCESS completes at E2. rsp_valid is high for the single cycle after E2.
  - Minimum accept-to-response latency is 2 cycles.
  - A new request can be accepted at E3, so peak throughput is one transfer per 3 cycles.
- **Wait states:** N wait cycles add N cycles of latency.
- **Timeout:** with PREADY held low, the abort occurs at the TIMEOUT-th ACCESS edge after entering ACCESS.
- **Simultaneous events:** if PREADY=1 on the same edge the counter reaches TIMEOUT, completion wins, with rsp_err=PSLVERR.
- **PSLVERR and PRDATA:** sampled only when PSEL&PENABLE&PREADY.

## Structure
- **Shared package apb_pkg:**
  - state enum apb_state_e {IDLE, SETUP, ACCESS};
  - default ADDR_W/DATA_W constants;
  - request/response struct typedefs for integrators.
- **Sub-module apb_wait_timer:** parametrised by TIMEOUT. Inputs are clear and count enable; output is an expired flag.
- **FSM and bus registers:** live in apb_master_ctrl.

## Test plan
- **Zero-wait write:** write addr 0x10, data 0xDEADBEEF, strb 0xF.
  - PSEL rises 1 cycle after accept; PENABLE rises 1 cycle later.
  - rsp_valid=1 with rsp_err=0, 3 cycles after accept.
  - PADDR=0x10, PWDATA=0xDEADBEEF, and PSTRB=0xF stable throughout.
- **Read with 3 wait states:** read addr 0x20; slave drives PRDATA=0x12345678 with PREADY low for 3 cycles.
  - rsp_rdata=0x12345678, with response 3 cycles later than zero-wait.
  - PSTRB=0 and PWDATA=0 throughout.
- **Slave error:** PSLVERR=1 with PREADY on a write → rsp_err=1.
- **Timeout:** TIMEOUT=4, PREADY held 0.
  - Abort after 4 ACCESS cycles.
  - rsp_err=1, rsp_rdata=0, PSEL=0; the next request is accepted normally.
- **Mid-ACCESS reset:** PRESET asserted in ACCESS → all bus outputs 0 next cycle, no rsp_valid, req_ready=1.
- **Back-to-back:** req_valid held high with two queued requests → second SETUP starts exactly 1 cycle after the first rsp_valid. req_ready is never high outside IDLE.
